pic_port_io: RTL and testbench

Bidirectional 8-bit I/O port stage for the structural PIC core. It consumes the direction word produced by the port's TRIS register, which resets to 0xFF (all inputs), and holds the port output latch. It drives pin output-enables, synchronises pin inputs, and returns the port read value to the data bus. It also generates the two port-sourced interrupt flags: edge interrupt on bit 0, and change-on-bits-7:4.

---
 rtl/pic_io_pkg.sv | 19 +
 rtl/sync_ff_vec.sv | 35 +++
 rtl/pic_port_io.sv | 117 +++++++++++
 tb/tb_pic_port_io.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pic_io_pkg.sv
// rtl/pic_io_pkg.sv - shared constants and helpers for the PIC port I/O stage
//
// Purpose : port width, change-interrupt bit mask, latch reset value, the
//           edge-interrupt bit index, and the edge-match helper.
// Ports   : none (package).
package pic_io_pkg;

    localparam int               PORT_W   = 8;
    localparam logic [PORT_W-1:0] CHG_MASK = 8'hF0;
    localparam logic [PORT_W-1:0] LAT_RST  = 8'h00;
    localparam int               INT_BIT  = 0;

    // True when the (prev -> cur) transition matches the selected polarity.
    function automatic logic edge_match(input logic cur, input logic prev,
                                        input logic rising);
        return rising ? (cur & ~prev) : (~cur & prev);
    endfunction

endpackage

// File: rtl/sync_ff_vec.sv
// rtl/sync_ff_vec.sv - multi-stage vector synchroniser with async reset to 0
//
// Purpose : brings asynchronous pad levels into the clock domain.
// Ports   : clock  - sampling clock
//           reset  - asynchronous active-high, clears every stage
//           d_in   - asynchronous input vector (WIDTH bits)
//           q_out  - synchronised vector, DEPTH edges behind d_in
module sync_ff_vec #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_out = stage_q[DEPTH-1];

endmodule

// File: rtl/pic_port_io.sv
// rtl/pic_port_io.sv - bidirectional 8-bit PIC port with edge and change interrupts
//
// Purpose : output latch, pad direction control, input synchroniser, bus read
//           mux, sticky bit-0 edge flag (intf) and bits-7:4 change flag (chgf).
//           The change-interrupt logic exists only when PIC_PORT_CHANGE_INT_EN
//           is defined; otherwise chgf is tied 0 and clr_chgf is ignored.
// Ports   : clock, reset        - core clock, async active-high reset
//           tris_in             - direction, 1 = input, 0 = output
//           wr_en, wr_data      - output latch write
//           rd_en, rd_data      - bus read strobe (arms change detect) and value
//           pin_in              - asynchronous pads
//           pin_out, pin_oe     - pad drive values and enables (1 = drive)
//           int_edge_sel        - bit-0 edge polarity, 1 = rising
//           clr_intf, clr_chgf  - flag clears (a same-cycle set wins)
//           intf, chgf          - sticky interrupt flags
module pic_port_io
    import pic_io_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [PORT_W-1:0] tris_in,
    input  logic              wr_en,
    input  logic [PORT_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [PORT_W-1:0] rd_data,
    input  logic [PORT_W-1:0] pin_in,
    output logic [PORT_W-1:0] pin_out,
    output logic [PORT_W-1:0] pin_oe,
    input  logic              int_edge_sel,
    input  logic              clr_intf,
    input  logic              clr_chgf,
    output logic              intf,
    output logic              chgf
);

    logic [PORT_W-1:0] lat_q, lat_d;
    logic [PORT_W-1:0] syn;
    logic [PORT_W-1:0] syn_d_q;
    logic              intf_q, intf_d;
    logic              edge_hit;

    sync_ff_vec #(
        .WIDTH (PORT_W),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d_in  (pin_in),
        .q_out (syn)
    );

    assign pin_out = lat_q;
    assign pin_oe  = ~tris_in;
    assign rd_data = (tris_in & syn) | (~tris_in & lat_q);

    // syn_d keeps tracking even while bit 0 is an output, so turning it into
    // an input never fabricates an edge from stale history.
    assign edge_hit = tris_in[INT_BIT] &
                      edge_match(syn[INT_BIT], syn_d_q[INT_BIT], int_edge_sel);

    always_comb begin
        lat_d  = wr_en ? wr_data : lat_q;
        intf_d = edge_hit | (intf_q & ~clr_intf);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_q   <= LAT_RST;
            syn_d_q <= '0;
            intf_q  <= 1'b0;
        end else begin
            lat_q   <= lat_d;
            syn_d_q <= syn;
            intf_q  <= intf_d;
        end
    end

    assign intf = intf_q;

`ifdef PIC_PORT_CHANGE_INT_EN
    logic [PORT_W-1:0] snap_q, snap_d;
    logic              armed_q, armed_d;
    logic              chgf_q, chgf_d;
    logic              chg_hit;

    // Only input-configured upper bits compare against the snapshot; the set
    // uses the old snapshot, so a read during a mismatch still sets this cycle.
    assign chg_hit = armed_q & (|((syn ^ snap_q) & tris_in & CHG_MASK));

    always_comb begin
        snap_d  = rd_en ? (syn & CHG_MASK) : snap_q;
        armed_d = armed_q | rd_en;
        chgf_d  = chg_hit | (chgf_q & ~clr_chgf);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap_q  <= '0;
            armed_q <= 1'b0;
            chgf_q  <= 1'b0;
        end else begin
            snap_q  <= snap_d;
            armed_q <= armed_d;
            chgf_q  <= chgf_d;
        end
    end

    assign chgf = chgf_q;
`else
    logic unused_chg;
    assign unused_chg = rd_en ^ clr_chgf;
    assign chgf       = 1'b0;
`endif

endmodule

// File: tb/tb_pic_port_io.sv
// tb/tb_pic_port_io.sv - directed self-checking bench for pic_port_io
module tb_pic_port_io;

    localparam int S = 2;
`ifdef PIC_PORT_CHANGE_INT_EN
    localparam bit CHG_EN = 1'b1;
`else
    localparam bit CHG_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tris_in = 8'hFF;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic [7:0] pin_in = 8'h00;
    logic [7:0] pin_out;
    logic [7:0] pin_oe;
    logic       int_edge_sel = 1'b0;
    logic       clr_intf = 1'b0;
    logic       clr_chgf = 1'b0;
    logic       intf;
    logic       chgf;

    int n_vec = 0;
    int n_err = 0;

    pic_port_io #(.SYNC_STAGES(S)) dut (
        .clock        (clock),
        .reset        (reset),
        .tris_in      (tris_in),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .pin_in       (pin_in),
        .pin_out      (pin_out),
        .pin_oe       (pin_oe),
        .int_edge_sel (int_edge_sel),
        .clr_intf     (clr_intf),
        .clr_chgf     (clr_chgf),
        .intf         (intf),
        .chgf         (chgf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pad samples recorded per edge since reset; syn is the sample
    // taken S-1 edges before the latest, syn_d the one before that.
    logic [7:0] samp [0:4095];
    int         m_n;
    logic [7:0] m_lat, m_snap;
    logic       m_intf, m_chgf, m_armed;

    function automatic logic [7:0] sample_at(input int idx);
        return (idx < 0) ? 8'h00 : samp[idx];
    endfunction

    task automatic model_clear();
        m_n = 0; m_lat = 8'h00; m_snap = 8'h00;
        m_intf = 1'b0; m_chgf = 1'b0; m_armed = 1'b0;
    endtask

    task automatic model_advance();
        logic [7:0] s_now, s_prev;
        logic       hit, cset;
        s_now  = sample_at(m_n - S);
        s_prev = sample_at(m_n - S - 1);
        hit = tris_in[0] && (int_edge_sel ? (s_now[0] && !s_prev[0])
                                          : (!s_now[0] && s_prev[0]));
        m_intf = hit || (m_intf && !clr_intf);
        cset = CHG_EN && m_armed && (((s_now ^ m_snap) & tris_in & 8'hF0) != 8'h00);
        m_chgf = cset || (m_chgf && !clr_chgf);
        if (rd_en) begin
            m_snap  = s_now & 8'hF0;
            m_armed = 1'b1;
        end
        if (wr_en) m_lat = wr_data;
        if (m_n < 4096) samp[m_n] = pin_in;
        m_n++;
    endtask

    // Inputs change 2 time units after each rising edge; at the falling edge
    // outputs are compared, then the model steps past the coming rising edge.
    initial begin
        model_clear();
        forever begin
            @(negedge clock);
            if (reset) model_clear();
            begin
                logic [7:0] syn_now, exp_rd;
                syn_now = sample_at(m_n - S);
                exp_rd  = 8'h00;
                for (int i = 0; i < 8; i++) exp_rd[i] = tris_in[i] ? syn_now[i] : m_lat[i];
                chk("pin_out", pin_out, m_lat);
                chk("pin_oe",  pin_oe,  ~tris_in);
                chk("rd_data", rd_data, exp_rd);
                chk("intf",    {7'd0, intf}, {7'd0, m_intf});
                chk("chgf",    {7'd0, chgf}, {7'd0, m_chgf});
            end
            if (!reset) model_advance();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    typedef struct {
        logic [7:0] tris;
        logic [7:0] pin;
        logic       we;
        logic [7:0] wd;
        logic       rd;
        logic       sel;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{8'hFF, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{8'hAA, 8'h0F, 1'b1, 8'hC3, 1'b0, 1'b0};
        tbl[2] = '{8'h55, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[3] = '{8'hF1, 8'h81, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[4] = '{8'hF1, 8'h40, 1'b1, 8'h7E, 1'b0, 1'b0};
        tbl[5] = '{8'h00, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[6] = '{8'hFF, 8'h21, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[7] = '{8'h0F, 8'hE0, 1'b1, 8'h99, 1'b1, 1'b0};

        tick(2);
        reset = 1'b0;
        tick(1);

        // Reset state with TRIS at its reset value
        chk("rst_pin_out", pin_out, 8'h00);
        chk("rst_pin_oe",  pin_oe,  8'h00);
        chk("rst_intf",    {7'd0, intf}, 8'h00);
        chk("rst_chgf",    {7'd0, chgf}, 8'h00);
        pin_in = 8'hA5;
        tick(1);
        chk("sync_1edge", rd_data, 8'h00);
        tick(1);
        chk("sync_2edge", rd_data, 8'hA5);

        // Mixed direction read mux
        tris_in = 8'h0F; wr_en = 1'b1; wr_data = 8'h3C;
        tick(1);
        wr_en = 1'b0;
        chk("mix_pin_oe",  pin_oe,  8'hF0);
        chk("mix_pin_out", pin_out, 8'h3C);
        pin_in = 8'h05;
        tick(2);
        chk("mix_rd", rd_data, 8'h35);

        // Edge interrupt on bit 0
        tris_in = 8'h01; int_edge_sel = 1'b1; pin_in = 8'h00;
        tick(3);
        clr_intf = 1'b1; tick(1); clr_intf = 1'b0;
        chk("intf_cleared", {7'd0, intf}, 8'h00);
        pin_in = 8'h01;
        tick(2);
        chk("intf_not_yet", {7'd0, intf}, 8'h00);
        tick(1);
        chk("intf_rise", {7'd0, intf}, 8'h01);
        clr_intf = 1'b1; tick(1); clr_intf = 1'b0;
        chk("intf_clr", {7'd0, intf}, 8'h00);
        pin_in = 8'h00;
        tick(4);
        chk("intf_fall_ignored", {7'd0, intf}, 8'h00);
        pin_in = 8'h01;
        tick(2);
        clr_intf = 1'b1; tick(1); clr_intf = 1'b0;
        chk("intf_set_beats_clr", {7'd0, intf}, 8'h01);
        clr_intf = 1'b1; tick(1); clr_intf = 1'b0;
        chk("intf_clr2", {7'd0, intf}, 8'h00);

        // Change interrupt on bits 7:4
        tris_in = 8'hFF;
        pin_in = 8'hF0; tick(3);
        pin_in = 8'h00; tick(3);
        chk("chg_unarmed", {7'd0, chgf}, 8'h00);
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
        chk("chg_armed_quiet", {7'd0, chgf}, 8'h00);
        pin_in = 8'h10;
        tick(3);
        chk("chg_set", {7'd0, chgf}, {7'd0, CHG_EN});
        rd_en = 1'b1; clr_chgf = 1'b1; tick(1); rd_en = 1'b0;
        chk("chg_set_beats_clr", {7'd0, chgf}, {7'd0, CHG_EN});
        tick(1); clr_chgf = 1'b0;
        chk("chg_resnap_clr", {7'd0, chgf}, 8'h00);
        pin_in = 8'h11;
        tick(3);
        chk("chg_bit0_ignored", {7'd0, chgf}, 8'h00);
        tris_in = 8'h0F; pin_in = 8'h91;
        tick(3);
        chk("chg_output_bit_ignored", {7'd0, chgf}, 8'h00);
        tris_in = 8'hFF;
        tick(1);
        chk("chg_bit7_as_input", {7'd0, chgf}, {7'd0, CHG_EN});

        // Asynchronous reset mid-operation
        reset = 1'b1;
        #1;
        chk("rst_async_chgf", {7'd0, chgf}, 8'h00);
        chk("rst_async_intf", {7'd0, intf}, 8'h00);
        chk("rst_async_lat",  pin_out, 8'h00);
        tick(2);
        reset = 1'b0;
        pin_in = 8'hF0; tick(3);
        pin_in = 8'h00; tick(3);
        chk("chg_unarmed_after_rst", {7'd0, chgf}, 8'h00);

        // Directed mixed vectors, checked by the per-cycle model
        for (int i = 0; i < 8; i++) begin
            tris_in = tbl[i].tris; pin_in = tbl[i].pin; wr_en = tbl[i].we;
            wr_data = tbl[i].wd; rd_en = tbl[i].rd; int_edge_sel = tbl[i].sel;
            tick(1);
            wr_en = 1'b0; rd_en = 1'b0;
            tick(2);
        end
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
